myproject_mul_pipe: RTL

- Parametrised, pipelined, multi-lane signed fixed-point multiplier with a valid/ready stream handshake.
- Successor to the single-stage combinational DSP48 multiply wrapper used throughout the generated layers (dense/attention MACs).
- Adds:
  - configurable latency
  - LANES parallel products sharing one handshake
  - output rescaling by a right shift
  - truncate or round-half-up modes
  - wrap or saturate overflow handling, with per-lane sticky overflow flags

---
 rtl/myproject_mul_pkg.sv | 26 ++
 rtl/myproject_mul_pipe_if.sv | 27 ++
 rtl/myproject_mul_lane.sv | 93 +++++++++
 rtl/myproject_mul_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/myproject_mul_pkg.sv
// Shared constants and helpers for the pipelined multi-lane multiplier.
package myproject_mul_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int OVF_WRAP    = 0;
  localparam int OVF_SAT     = 1;

  localparam int MIN_STAGE = 1;
  localparam int MAX_STAGE = 8;

  // Legal pipeline depth.
  function automatic bit stage_ok(input int n);
    return (n >= MIN_STAGE) && (n <= MAX_STAGE);
  endfunction

  // Two's-complement bounds of a w-bit signed value (w <= 63).
  function automatic longint s_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint s_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_if.sv
// Stream bundle: input handshake, output handshake and overflow flags.
interface myproject_mul_pipe_if #(
  parameter int LANES      = 1,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 26
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DIN0_WIDTH-1:0]   din0;
  logic [LANES*DIN1_WIDTH-1:0]   din1;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DOUT_WIDTH-1:0]   dout;
  logic [LANES-1:0]              ovf_sticky;
  logic                          ovf_clr;

  modport master (
    output in_valid, din0, din1, out_ready, ovf_clr,
    input  in_ready, out_valid, dout, ovf_sticky
  );

  modport slave (
    input  in_valid, din0, din1, out_ready, ovf_clr,
    output in_ready, out_valid, dout, ovf_sticky
  );
endinterface

// File: rtl/myproject_mul_lane.sv
// One lane: signed multiply, optional half-up rounding, arithmetic right
// shift, wrap/saturate to the output width, and the per-result overflow bit.
// Data registers advance only when en is high so the lane tracks the
// shared valid chain in the top.
module myproject_mul_lane
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ROUND_MODE = RND_TRUNC,
  parameter int SAT_MODE   = OVF_WRAP
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         en,
  input  logic signed [DIN0_WIDTH-1:0] a,
  input  logic signed [DIN1_WIDTH-1:0] b,
  output logic signed [DOUT_WIDTH-1:0] y,
  output logic                         ovf
);
  localparam int W  = DIN0_WIDTH + DIN1_WIDTH;
  // Result registers after the product: all stages when NUM_STAGE==1,
  // otherwise everything after the product register.
  localparam int RS = (NUM_STAGE == 1) ? 1 : NUM_STAGE - 1;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W:0] HALF =
    (ROUND_MODE == RND_HALF_UP && SHIFT > 0) ? ((W + 1)'(1) << HS) : '0;

  logic signed [W-1:0]      prod_d;
  logic signed [W-1:0]      prod_src;
  logic signed [W:0]        p_ext, p_rnd, q;
  logic signed [DOUT_WIDTH-1:0] res;
  logic                     res_ovf;
  logic [RS-1:0][DOUT_WIDTH:0] res_q, res_d;

  // Full-width signed product; operands sign-extended so the product is exact.
  always_comb begin
    prod_d = W'(a) * W'(b);
  end

  if (NUM_STAGE == 1) begin : g_comb
    assign prod_src = prod_d;
  end else begin : g_reg
    logic signed [W-1:0] prod_q;
    // Stage 1: product register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)  prod_q <= '0;
      else if (en)    prod_q <= prod_d;
    end
    assign prod_src = prod_q;
  end

  // Round at W+1 bits so adding the half LSB can never wrap, then shift.
  always_comb begin
    p_ext = (W + 1)'(prod_src);
    p_rnd = p_ext + HALF;
    q     = p_rnd >>> SHIFT;
  end

  if (DOUT_WIDTH >= W + 1) begin : g_wide
    assign res     = DOUT_WIDTH'(q);
    assign res_ovf = 1'b0;
  end else begin : g_narrow
    logic hi_ok;
    // In range iff every bit above the output sign bit copies it.
    assign hi_ok   = (&q[W:DOUT_WIDTH-1]) | ~(|q[W:DOUT_WIDTH-1]);
    assign res_ovf = ~hi_ok;
    if (SAT_MODE == OVF_SAT) begin : g_sat
      assign res = res_ovf ? {q[W], {(DOUT_WIDTH-1){~q[W]}}} : q[DOUT_WIDTH-1:0];
    end else begin : g_wrap
      assign res = q[DOUT_WIDTH-1:0];
    end
  end

  // Result shift chain: entry 0 takes the fresh result, the rest are delays.
  always_comb begin
    res_d    = res_q;
    res_d[0] = {res_ovf, res};
    for (int k = 1; k < RS; k++) res_d[k] = res_q[k-1];
  end

  // Result registers; hold while the pipe is stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) res_q <= '0;
    else if (en)   res_q <= res_d;
  end

  assign y   = res_q[RS-1][DOUT_WIDTH-1:0];
  assign ovf = res_q[RS-1][DOUT_WIDTH];
endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined multi-lane fixed-point multiplier. One valid chain and one
// advance signal drive every lane; the whole pipe moves or holds together.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 26,
  parameter int NUM_STAGE  = 3,
  parameter int LANES      = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND_MODE = RND_TRUNC,
  parameter int SAT_MODE   = OVF_WRAP
) (
  input logic              ap_clk,
  input logic              ap_rst_n,
  myproject_mul_pipe_if.slave bus
);
  if (!stage_ok(NUM_STAGE)) begin : g_err_stage
    $error("myproject_mul_pipe: NUM_STAGE=%0d outside %0d..%0d", NUM_STAGE, MIN_STAGE, MAX_STAGE);
  end
  if (SHIFT < 0 || SHIFT > DIN0_WIDTH + DIN1_WIDTH - 1) begin : g_err_shift
    $error("myproject_mul_pipe: SHIFT=%0d out of range", SHIFT);
  end
  if (ROUND_MODE != RND_TRUNC && ROUND_MODE != RND_HALF_UP) begin : g_err_rnd
    $error("myproject_mul_pipe: bad ROUND_MODE=%0d", ROUND_MODE);
  end
  if (SAT_MODE != OVF_WRAP && SAT_MODE != OVF_SAT) begin : g_err_sat
    $error("myproject_mul_pipe: bad SAT_MODE=%0d", SAT_MODE);
  end
  if (LANES < 1) begin : g_err_lanes
    $error("myproject_mul_pipe: LANES must be >= 1");
  end

  logic                              adv;
  logic                              out_valid;
  logic [NUM_STAGE:1]                vld_pipe_q, vld_pipe_d;
  logic [LANES-1:0]                  sticky_q, sticky_d;
  logic [LANES-1:0]                  lane_ovf;
  logic [LANES-1:0][DOUT_WIDTH-1:0]  lane_y;

  assign out_valid = vld_pipe_q[NUM_STAGE];
  assign adv       = ~out_valid | bus.out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    myproject_mul_lane #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .NUM_STAGE  (NUM_STAGE),
      .SHIFT      (SHIFT),
      .ROUND_MODE (ROUND_MODE),
      .SAT_MODE   (SAT_MODE)
    ) u_lane (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .en       (adv),
      .a        (bus.din0[i*DIN0_WIDTH +: DIN0_WIDTH]),
      .b        (bus.din1[i*DIN1_WIDTH +: DIN1_WIDTH]),
      .y        (lane_y[i]),
      .ovf      (lane_ovf[i])
    );
  end

  // Valid chain: shift on advance (bubbles included), otherwise hold.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) begin
      vld_pipe_d[1] = bus.in_valid;
      for (int k = 2; k <= NUM_STAGE; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    end
  end

  // Sticky flags: clear first, then OR in delivered overflows so a
  // coincident event survives the clear.
  always_comb begin
    sticky_d = bus.ovf_clr ? '0 : sticky_q;
    if (out_valid && bus.out_ready) sticky_d = sticky_d | lane_ovf;
  end

  // Control state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe_q <= '0;
      sticky_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.in_ready   = adv;
  assign bus.out_valid  = out_valid;
  assign bus.dout       = lane_y;
  assign bus.ovf_sticky = sticky_q;
endmodule
